// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared pipeline-control types and defaults
// Purpose: FSM state encoding for pipe_ctrl and the default stage count.
// Ports: none (package).
package cpu_pkg;

    localparam int STAGE_NUM_DEF = 5;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        REDIR_WAIT = 2'd1,
        DRAIN      = 2'd2,
        HALTED     = 2'd3
    } pipe_ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl_prio.sv
// rtl/pipe_ctrl_prio.sv - highest-index hazard resolution
// Purpose: finds the highest-index asserted hazard and produces its one-hot
//          bubble position and a thermometer stall mask covering it and all
//          younger (lower-index) stages.
// Ports:
//   hazard  in  N  per-stage hazard requests
//   onehot  out N  single bit at the winning hazard (0 if none)
//   mask    out N  bits [i:0] set for winning index i (0 if none)
module pipe_ctrl_prio #(
    parameter int N = 5
) (
    input  logic [N-1:0] hazard,
    output logic [N-1:0] onehot,
    output logic [N-1:0] mask
);

    always_comb begin
        onehot = '0;
        // Ascending scan: the last hit written is the highest index.
        for (int i = 0; i < N; i++) begin
            if (hazard[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        logic acc;
        acc  = 1'b0;
        mask = '0;
        // Sweep from the oldest stage down so every stage at or below the
        // winner picks up the stall.
        for (int i = N - 1; i >= 0; i--) begin
            acc     = acc | onehot[i];
            mask[i] = acc;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush/redirect/halt controller
// Purpose: merges hazards, redirects and halt requests into per-stage stall,
//          flush and flush_force controls; optional performance counters are
//          built when PIPE_CTRL_PERF_EN is defined (otherwise tied to 0).
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   inst_valid, hazard         per-stage valid and hazard request
//   redirect_valid/_stage/_trap, redirect_ack   redirect handshake
//   fetch_ready                fetch accepts a new PC
//   halt_req, halt_ack         halt handshake (halt_ack registered)
//   stall, flush, flush_force  per-stage controls (combinational)
//   perf_clr, stall_cnt, redir_cnt  performance counters
module pipe_ctrl
    import cpu_pkg::*;
#(
    parameter int STAGE_NUM = STAGE_NUM_DEF,
    parameter int CNT_WIDTH = 32,
    localparam int SW = $clog2(STAGE_NUM)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [STAGE_NUM-1:0] inst_valid,
    input  logic [STAGE_NUM-1:0] hazard,
    input  logic                 redirect_valid,
    input  logic [SW-1:0]        redirect_stage,
    input  logic                 redirect_trap,
    output logic                 redirect_ack,
    input  logic                 fetch_ready,
    input  logic                 halt_req,
    output logic                 halt_ack,
    output logic [STAGE_NUM-1:0] stall,
    output logic [STAGE_NUM-1:0] flush,
    output logic [STAGE_NUM-1:0] flush_force,
    input  logic                 perf_clr,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] redir_cnt
);

    pipe_ctrl_state_e state_q, state_d;
    logic [STAGE_NUM-1:0] hz_onehot, hz_mask;
    logic [STAGE_NUM-1:0] redir_ff, trap_flush;
    logic                 redir_acc;
    logic                 drained;

    pipe_ctrl_prio #(.N(STAGE_NUM)) u_prio (
        .hazard (hazard),
        .onehot (hz_onehot),
        .mask   (hz_mask)
    );

    assign redir_acc    = redirect_valid && (state_q != HALTED);
    assign redirect_ack = redir_acc;
    // Fetch stage holds no committed work, so only older stages gate the drain.
    assign drained      = (inst_valid[STAGE_NUM-1:1] == '0);

    // Redirect from stage k kills everything younger than k; an out-of-range
    // stage number kills the whole pipe. A trap also kills stage k itself.
    always_comb begin
        redir_ff   = '0;
        trap_flush = '0;
        for (int i = 0; i < STAGE_NUM; i++) begin
            redir_ff[i]   = redir_acc &&
                            ((int'(redirect_stage) >= STAGE_NUM) || (i < int'(redirect_stage)));
            trap_flush[i] = redir_acc && redirect_trap && (int'(redirect_stage) == i);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= RUN;
            halt_ack <= 1'b0;
        end else begin
            state_q  <= state_d;
            halt_ack <= (state_d == HALTED);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (redir_acc)     state_d = fetch_ready ? RUN : REDIR_WAIT;
                else if (halt_req) state_d = DRAIN;
            end
            REDIR_WAIT: begin
                if (redir_acc)        state_d = fetch_ready ? RUN : REDIR_WAIT;
                else if (fetch_ready) state_d = RUN;
            end
            DRAIN: begin
                if (!halt_req)      state_d = RUN;
                else if (redir_acc) state_d = DRAIN;
                else if (drained)   state_d = HALTED;
            end
            HALTED: begin
                if (!halt_req) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        stall       = hz_mask;
        flush       = hz_onehot | trap_flush;
        flush_force = redir_ff;
        unique case (state_q)
            RUN: ;
            REDIR_WAIT: flush_force[0] = 1'b1;
            DRAIN: begin
                stall[0] = 1'b1;
                flush[0] = 1'b1;
            end
            HALTED: begin
                stall       = '1;
                flush       = '0;
                flush_force = '0;
            end
            default: ;
        endcase
        flush = flush | flush_force;
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_WIDTH-1:0] stall_cnt_q, redir_cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else if (perf_clr) begin
            stall_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            if (stall[0] && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
            if (redir_acc && (redir_cnt_q != '1)) redir_cnt_q <= redir_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign redir_cnt = redir_cnt_q;
`else
    logic unused_perf;
    assign unused_perf = perf_clr;
    assign stall_cnt   = '0;
    assign redir_cnt   = '0;
`endif

    logic unused_iv0;
    assign unused_iv0 = inst_valid[0];

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard bench for pipe_ctrl
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [4:0] inst_valid = '0, hazard = '0;
    logic       redirect_valid = 1'b0, redirect_trap = 1'b0;
    logic [2:0] redirect_stage = '0;
    logic       redirect_ack, fetch_ready = 1'b0, halt_req = 1'b0, halt_ack;
    logic [4:0] stall, flush, flush_force;
    logic       perf_clr = 1'b0;
    logic [3:0] stall_cnt, redir_cnt;

    always #5 clk = ~clk;

    pipe_ctrl #(.STAGE_NUM(5), .CNT_WIDTH(4)) dut (
        .clk(clk), .rstn(rstn), .inst_valid(inst_valid), .hazard(hazard),
        .redirect_valid(redirect_valid), .redirect_stage(redirect_stage),
        .redirect_trap(redirect_trap), .redirect_ack(redirect_ack),
        .fetch_ready(fetch_ready), .halt_req(halt_req), .halt_ack(halt_ack),
        .stall(stall), .flush(flush), .flush_force(flush_force),
        .perf_clr(perf_clr), .stall_cnt(stall_cnt), .redir_cnt(redir_cnt)
    );

    typedef struct {
        string      name;
        logic [4:0] st, fl, ff;
        logic       ack, hack;
        bit         chk;
        logic [3:0] sc, rc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // staged stimulus, applied right after the next rising edge
    logic       n_rstn, n_rv, n_rt, n_fr, n_hr, n_pc;
    logic [4:0] n_iv, n_hz;
    logic [2:0] n_rs;
    bit         x_chk = 0;
    logic [3:0] x_sc = '0, x_rc = '0;

    task automatic clr_in();
        n_rstn = 1'b1; n_iv = '0; n_hz = '0; n_rv = 1'b0; n_rs = '0;
        n_rt = 1'b0; n_fr = 1'b0; n_hr = 1'b0; n_pc = 1'b0;
    endtask

    task automatic expect_cnt(input int sc, input int rc);
        x_chk = 1;
        x_sc  = PERF ? 4'(sc) : 4'd0;
        x_rc  = PERF ? 4'(rc) : 4'd0;
    endtask

    task automatic tick(input string nm, input logic [4:0] es, input logic [4:0] ef,
                        input logic [4:0] eff, input logic ea, input logic eh);
        exp_t e;
        @(posedge clk);
        #1;
        rstn = n_rstn; inst_valid = n_iv; hazard = n_hz; redirect_valid = n_rv;
        redirect_stage = n_rs; redirect_trap = n_rt; fetch_ready = n_fr;
        halt_req = n_hr; perf_clr = n_pc;
        e.name = nm; e.st = es; e.fl = ef; e.ff = eff; e.ack = ea; e.hack = eh;
        e.chk = x_chk; e.sc = x_sc; e.rc = x_rc;
        x_chk = 0;
        sb.push_back(e);
    endtask

    task automatic cmp(input string nm, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b exp %b", nm, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            cmp({e.name, ".stall"}, {3'b0, stall}, {3'b0, e.st});
            cmp({e.name, ".flush"}, {3'b0, flush}, {3'b0, e.fl});
            cmp({e.name, ".flush_force"}, {3'b0, flush_force}, {3'b0, e.ff});
            cmp({e.name, ".redirect_ack"}, {7'b0, redirect_ack}, {7'b0, e.ack});
            cmp({e.name, ".halt_ack"}, {7'b0, halt_ack}, {7'b0, e.hack});
            if (e.chk) begin
                cmp({e.name, ".stall_cnt"}, {4'b0, stall_cnt}, {4'b0, e.sc});
                cmp({e.name, ".redir_cnt"}, {4'b0, redir_cnt}, {4'b0, e.rc});
            end
        end
    end

    initial begin
        clr_in();
        // reset: combinational outputs still follow RUN rules
        n_rstn = 1'b0; n_hz = 5'b00110; expect_cnt(0, 0);
        tick("rst", 5'b00111, 5'b00100, 5'b00000, 0, 0);
        clr_in(); expect_cnt(0, 0);
        tick("idle", 5'b00000, 5'b00000, 5'b00000, 0, 0);
        // hazard priority
        clr_in(); n_hz = 5'b00110; tick("hz00110", 5'b00111, 5'b00100, 5'b00000, 0, 0);
        clr_in(); n_hz = 5'b10001; tick("hz10001", 5'b11111, 5'b10000, 5'b00000, 0, 0);
        clr_in(); n_hz = 5'b00001; tick("hz00001", 5'b00001, 5'b00001, 5'b00000, 0, 0);
        // redirect from stage 2 while fetch busy
        clr_in(); n_rv = 1; n_rs = 3'd2;
        tick("redir0", 5'b00000, 5'b00011, 5'b00011, 1, 0);
        clr_in(); tick("rwait1", 5'b00000, 5'b00001, 5'b00001, 0, 0);
        clr_in(); tick("rwait2", 5'b00000, 5'b00001, 5'b00001, 0, 0);
        clr_in(); n_fr = 1; tick("rwait3", 5'b00000, 5'b00001, 5'b00001, 0, 0);
        clr_in(); n_fr = 1; expect_cnt(3, 1);
        tick("back_run", 5'b00000, 5'b00000, 5'b00000, 0, 0);
        // trap redirect combined with oldest-stage hazard
        clr_in(); n_rv = 1; n_rs = 3'd2; n_rt = 1; n_hz = 5'b10000; n_fr = 1;
        tick("trap_hz", 5'b11111, 5'b10111, 5'b00011, 1, 0);
        clr_in(); n_rv = 1; n_rs = 3'd7; n_fr = 1;
        tick("redir_oor", 5'b00000, 5'b11111, 5'b11111, 1, 0);
        clr_in(); n_rv = 1; n_rs = 3'd0; n_rt = 1; n_fr = 1;
        tick("trap_s0", 5'b00000, 5'b00001, 5'b00000, 1, 0);
        // halt and drain
        clr_in(); n_hr = 1; n_iv = 5'b11110; tick("halt_req", 5'b00000, 5'b00000, 5'b00000, 0, 0);
        clr_in(); n_hr = 1; n_iv = 5'b11100; tick("drain1", 5'b00001, 5'b00001, 5'b00000, 0, 0);
        clr_in(); n_hr = 1; n_iv = 5'b11000; tick("drain2", 5'b00001, 5'b00001, 5'b00000, 0, 0);
        clr_in(); n_hr = 1; n_iv = 5'b10000; tick("drain3", 5'b00001, 5'b00001, 5'b00000, 0, 0);
        clr_in(); n_hr = 1; n_iv = 5'b00000; tick("drain4", 5'b00001, 5'b00001, 5'b00000, 0, 0);
        clr_in(); n_hr = 1; n_rv = 1; n_rs = 3'd2; n_rt = 1; n_hz = 5'b00110;
        tick("halted", 5'b11111, 5'b00000, 5'b00000, 0, 1);
        clr_in(); tick("unhalt", 5'b11111, 5'b00000, 5'b00000, 0, 1);
        clr_in(); tick("run_again", 5'b00000, 5'b00000, 5'b00000, 0, 0);
        // redirect during drain, then halt_req drop
        clr_in(); n_hr = 1; n_iv = 5'b00010; tick("halt_req2", 5'b00000, 5'b00000, 5'b00000, 0, 0);
        clr_in(); n_hr = 1; n_rv = 1; n_rs = 3'd3;
        tick("drain_redir", 5'b00001, 5'b00111, 5'b00111, 1, 0);
        clr_in(); tick("drain_drop", 5'b00001, 5'b00001, 5'b00000, 0, 0);
        clr_in(); expect_cnt(12, 5);
        tick("run_after_drop", 5'b00000, 5'b00000, 5'b00000, 0, 0);
        // reset while waiting for fetch
        clr_in(); n_rv = 1; n_rs = 3'd1;
        tick("redir_s1", 5'b00000, 5'b00001, 5'b00001, 1, 0);
        clr_in(); n_rstn = 1'b0; expect_cnt(0, 0);
        tick("rst_in_wait", 5'b00000, 5'b00000, 5'b00000, 0, 0);
        clr_in(); expect_cnt(0, 0);
        tick("post_rst", 5'b00000, 5'b00000, 5'b00000, 0, 0);
        // counter saturation and clear
        for (int j = 0; j < 20; j++) begin
            clr_in(); n_hz = 5'b00001; expect_cnt((j > 15) ? 15 : j, 0);
            tick($sformatf("sat%0d", j), 5'b00001, 5'b00001, 5'b00000, 0, 0);
        end
        clr_in(); expect_cnt(15, 0);
        tick("sat_hold", 5'b00000, 5'b00000, 5'b00000, 0, 0);
        clr_in(); n_pc = 1; n_hz = 5'b00001; expect_cnt(15, 0);
        tick("clr_cyc", 5'b00001, 5'b00001, 5'b00000, 0, 0);
        clr_in(); expect_cnt(0, 0);
        tick("cleared", 5'b00000, 5'b00000, 5'b00000, 0, 0);
        clr_in(); expect_cnt(0, 0);
        tick("cleared2", 5'b00000, 5'b00000, 5'b00000, 0, 0);

        for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending exp 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
